// File: rtl/mux8_rr_arbiter_if.sv
// mux8_rr_arbiter_if
// Groups the request/grant bundle between the requesters and the round-robin
// arbiter that drives the shared 8:1 mux select.
//   en        arbitration enable (requester side -> arbiter)
//   req[7:0]  request vector, bit i is mux input d[i] (requester side -> arbiter)
//   gnt[7:0]  one-hot grant, zero when idle (arbiter -> requester side)
//   sel[2:0]  binary index of the grantee, feeds mux s (arbiter -> requester side)
//   gnt_valid high while gnt is non-zero (arbiter -> requester side)
//   hold_cnt  cycles the current grantee has held the grant (arbiter -> requester side)
interface mux8_rr_arbiter_if #(
  parameter int CNT_W = 4
);
  logic             en;
  logic [7:0]       req;
  logic [7:0]       gnt;
  logic [2:0]       sel;
  logic             gnt_valid;
  logic [CNT_W-1:0] hold_cnt;

  // Requester side: drives enable and requests, observes the grant.
  modport master (
    output en,
    output req,
    input  gnt,
    input  sel,
    input  gnt_valid,
    input  hold_cnt
  );

  // Arbiter side.
  modport slave (
    input  en,
    input  req,
    output gnt,
    output sel,
    output gnt_valid,
    output hold_cnt
  );
endinterface

// File: rtl/mux8_rr_arbiter.sv
// mux8_rr_arbiter
// Round-robin arbiter and select sequencer for a shared 8:1 single-bit mux.
// Grants one requester at a time, bounds the hold time under contention to
// MAX_HOLD cycles, and hands off back-to-back when another requester waits.
// All outputs are registered so sel can drive the mux select directly.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  mux8_rr_arbiter_if.slave: en, req in; gnt, sel, gnt_valid, hold_cnt out
// Parameters:
//   MAX_HOLD  max consecutive grant cycles while contended (1..15)
//   CNT_W     hold counter width, MAX_HOLD < 2**CNT_W
module mux8_rr_arbiter #(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 4
) (
  input  logic                clk,
  input  logic                rst,
  mux8_rr_arbiter_if.slave    bus
);

  localparam logic [CNT_W-1:0] MAX_HOLD_C = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] ONE_C      = CNT_W'(1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state_reg;
  logic [7:0]       gnt_reg;
  logic [2:0]       sel_reg;
  logic             gnt_valid_reg;
  logic [CNT_W-1:0] hold_reg;
  logic [2:0]       ptr_reg;

  logic [7:0]       others;
  logic [2:0]       sel_inc;
  logic [2:0]       pick_new;
  logic [2:0]       pick_hand;

  // First set bit of v at or above index p, wrapping 7 -> 0.
  function automatic logic [2:0] pick(input logic [7:0] v, input logic [2:0] p);
    logic [2:0] k;
    logic [2:0] idx;
    logic       found;
    k     = p;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idx = p + 3'(i);
      if (!found && v[idx]) begin
        k     = idx;
        found = 1'b1;
      end
    end
    return k;
  endfunction

  always_comb begin
    others    = bus.req & ~(8'b1 << sel_reg);
    sel_inc   = sel_reg + 3'd1;
    pick_new  = pick(bus.req, ptr_reg);
    // Handoff search starts just past the outgoing grantee.
    pick_hand = pick(others, sel_inc);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      gnt_reg       <= 8'h00;
      sel_reg       <= 3'd0;
      gnt_valid_reg <= 1'b0;
      hold_reg      <= '0;
      ptr_reg       <= 3'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.en && (bus.req != 8'h00)) begin
            state_reg     <= GRANT;
            gnt_reg       <= 8'b1 << pick_new;
            sel_reg       <= pick_new;
            gnt_valid_reg <= 1'b1;
            hold_reg      <= ONE_C;
          end
        end
        GRANT: begin
          if (!bus.en) begin
            // sel keeps its last value while idle.
            state_reg     <= IDLE;
            gnt_reg       <= 8'h00;
            gnt_valid_reg <= 1'b0;
            hold_reg      <= '0;
            ptr_reg       <= sel_inc;
          end else if (!bus.req[sel_reg] ||
                       ((hold_reg == MAX_HOLD_C) && (others != 8'h00))) begin
            // Voluntary release or forced rotation: the served requester
            // drops to lowest priority.
            ptr_reg <= sel_inc;
            if (others != 8'h00) begin
              gnt_reg  <= 8'b1 << pick_hand;
              sel_reg  <= pick_hand;
              hold_reg <= ONE_C;
            end else begin
              state_reg     <= IDLE;
              gnt_reg       <= 8'h00;
              gnt_valid_reg <= 1'b0;
              hold_reg      <= '0;
            end
          end else if (hold_reg < MAX_HOLD_C) begin
            hold_reg <= hold_reg + ONE_C;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.gnt       = gnt_reg;
  assign bus.sel       = sel_reg;
  assign bus.gnt_valid = gnt_valid_reg;
  assign bus.hold_cnt  = hold_reg;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed bench for mux8_rr_arbiter with MAX_HOLD = 4.
module tb_mux8_rr_arbiter;
  logic clk;
  logic rst;
  int   passed;
  int   total;

  mux8_rr_arbiter_if #(.CNT_W(4)) bus ();

  mux8_rr_arbiter #(.MAX_HOLD(4), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_all(input string tag, input logic [7:0] g, input logic [2:0] s,
                         input logic v, input logic [3:0] h);
    chk({tag, ".gnt"},       32'(bus.gnt),       32'(g));
    chk({tag, ".sel"},       32'(bus.sel),       32'(s));
    chk({tag, ".gnt_valid"}, 32'(bus.gnt_valid), 32'(v));
    chk({tag, ".hold_cnt"},  32'(bus.hold_cnt),  32'(h));
  endtask

  // Advance one edge and settle at the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Assert reset between edges, check the immediate clear, release on a falling edge.
  task automatic do_reset(input string tag);
    #2 rst = 1'b1;
    #1 chk_all(tag, 8'h00, 3'd0, 1'b0, 4'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    passed  = 0;
    total   = 0;
    rst     = 1'b1;
    bus.en  = 1'b0;
    bus.req = 8'h00;
    @(negedge clk);
    chk_all("por", 8'h00, 3'd0, 1'b0, 4'd0);
    rst = 1'b0;

    // Single requester: held forever, hold_cnt saturates.
    bus.en  = 1'b1;
    bus.req = 8'h20;
    for (int i = 1; i <= 20; i++) begin
      step();
      chk_all($sformatf("single%0d", i), 8'h20, 3'd5, 1'b1, 4'((i > 4) ? 4 : i));
    end

    // Full contention: 0..7 then 0, each exactly 4 cycles.
    do_reset("rst1");
    bus.req = 8'hFF;
    for (int g = 0; g < 9; g++) begin
      for (int h = 1; h <= 4; h++) begin
        step();
        chk_all($sformatf("full_g%0d_h%0d", g, h), 8'b1 << (g % 8), 3'(g % 8), 1'b1, 4'(h));
      end
    end

    // Reset in the middle of a contended grant, then first grant from ptr 0.
    do_reset("rst_mid");
    step();
    chk_all("post_rst", 8'h01, 3'd0, 1'b1, 4'd1);

    // Wrap and fairness.
    do_reset("rst2");
    bus.req = 8'h40;
    step();
    chk_all("wrap_g6", 8'h40, 3'd6, 1'b1, 4'd1);
    bus.req = 8'h44;
    step();
    chk_all("wrap_g6b", 8'h40, 3'd6, 1'b1, 4'd2);
    bus.req = 8'h04;
    step();
    chk_all("wrap_to2", 8'h04, 3'd2, 1'b1, 4'd1);
    bus.req = 8'h44;
    step();
    chk_all("fair_h2", 8'h04, 3'd2, 1'b1, 4'd2);
    step();
    chk_all("fair_h3", 8'h04, 3'd2, 1'b1, 4'd3);
    step();
    chk_all("fair_h4", 8'h04, 3'd2, 1'b1, 4'd4);
    step();
    chk_all("fair_to6", 8'h40, 3'd6, 1'b1, 4'd1);

    // Voluntary handoff with no bubble.
    do_reset("rst3");
    bus.req = 8'h03;
    step();
    chk_all("vol_g0", 8'h01, 3'd0, 1'b1, 4'd1);
    step();
    chk_all("vol_g0b", 8'h01, 3'd0, 1'b1, 4'd2);
    bus.req = 8'h02;
    step();
    chk_all("vol_g1", 8'h02, 3'd1, 1'b1, 4'd1);

    // Enable gating: release, no grants while disabled, resume from grantee+1.
    bus.en  = 1'b0;
    bus.req = 8'h0A;
    step();
    chk_all("en_off", 8'h00, 3'd1, 1'b0, 4'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_all($sformatf("en_low%0d", i), 8'h00, 3'd1, 1'b0, 4'd0);
    end
    bus.en = 1'b1;
    step();
    chk_all("en_on", 8'h08, 3'd3, 1'b1, 4'd1);

    // Sole requester drops with nobody waiting: back to idle.
    bus.req = 8'h00;
    step();
    chk_all("drop_idle", 8'h00, 3'd3, 1'b0, 4'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mux8_rr_arbiter.md
# mux8_rr_arbiter

Round-robin arbiter and select sequencer for the shared 8:1 single-bit mux (`mux`, ports `d[7:0]`, `s[2:0]`, `out`). Up to eight requesters compete for the mux output path. The arbiter grants one requester at a time, drives the mux select, and enforces a bounded hold time so that no requester can starve the others. All outputs are registered, so `sel` connects straight to the mux `s` input.

## Interface
- `MAX_HOLD`, default 4: maximum consecutive grant cycles while another requester is waiting; legal range 1..15.
- `CNT_W`, default 4: hold counter width; must satisfy MAX_HOLD < 2^CNT_W.
- `clk`  in  1  system clock, rising-edge active.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  arbitration enable; when low, no new grants are issued and any current grant is released.
- `req`  in  8  request vector; bit i is requester i (mux input `d[i]`).
- `gnt`  out  8  one-hot grant; all zero when idle.
- `sel`  out  3  binary index of the current grantee; drives mux `s`.
- `gnt_valid`  out  1  high while `gnt` is non-zero.
- `hold_cnt`  out  CNT_W  number of cycles the current grantee has held the grant (1 = first cycle).

## Operation
- **Reset values**: `gnt`=0, `sel`=0, `gnt_valid`=0, `hold_cnt`=0, priority pointer `ptr`=0, state IDLE.
- **States**:
  - IDLE: no grant.
  - GRANT: exactly one `gnt` bit is set; that bit matches `sel`.
- **Selection function pick(v, p)**: the first set bit of `v` searched upward from index p, wrapping 7→0.
- **IDLE**:
  - If `en`=1 and `req`≠0: grant k = pick(`req`, `ptr`), set `gnt`=1<<k, `sel`=k, `hold_cnt`=1, go to GRANT.
  - Otherwise stay in IDLE.
- **GRANT**: let c = `sel`. Evaluate release conditions in this priority order:
  1. `en`=0: release. Go to IDLE, `gnt`=0, `hold_cnt`=0, `ptr`=c+1 mod 8.
  2. `req[c]`=0: voluntary release.
  3. `hold_cnt`=MAX_HOLD and (`req` & ~(1<<c))≠0: forced rotation.
  4. Otherwise keep the grant. `hold_cnt` increments, saturating at MAX_HOLD. A sole requester keeps the grant indefinitely.
- **On release case 2 or 3**:
  - Set `ptr`=c+1 mod 8 and r = `req` & ~(1<<c).
  - If r≠0: hand off in the same edge with no bubble to k = pick(r, c+1 mod 8), `hold_cnt`=1.
  - Else go to IDLE.
- `sel` holds its last value in IDLE; the mux output is don't-care there. `sel` is not reset-forced except on `rst`.
- `ptr` updates only on release, so a requester that has just been served has the lowest priority next.
- **Reset mid-operation**: all state clears immediately (asynchronously). After `rst` falls, the first grant uses `ptr`=0.

## Timing
- Request-to-grant latency: 1 cycle. `req` sampled at edge n gives `gnt` valid after edge n.
- Release latency: 1 cycle. A `req[c]` drop or `en` drop at edge n clears or moves `gnt` at edge n.
- Handoff between requesters is back-to-back. `gnt_valid` stays high when another requester is pending.
- Forced rotation: a grantee holds for exactly MAX_HOLD cycles when contended.
- Worst-case wait for any continuously asserted requester: 7×MAX_HOLD cycles.
- `gnt`, `sel`, `gnt_valid` and `hold_cnt` change only on a `clk` edge or on assertion of `rst`.

## Test plan
- **Reset**: assert `rst` while `req`=8'hFF and in GRANT → `gnt`=0, `sel`=0, `gnt_valid`=0, `hold_cnt`=0 immediately. After release with `en`=1, the next edge grants `gnt`=8'h01.
- **Single requester**: `req`=8'h20 for 20 cycles → `gnt`=8'h20 and `sel`=5 from the first edge and held for all 20 cycles. `hold_cnt` saturates at 4. No IDLE gap.
- **Full contention**: `req`=8'hFF, MAX_HOLD=4 → grants 0,1,…,7,0 in sequence, each exactly 4 cycles. `gnt_valid` is continuously 1. The mux `out` follows `d[sel]`.
- **Wrap and fairness**: grant 6 released by dropping `req[6]`, with `req`=8'h44 beforehand → the next grant is 2 (search wraps from 7). A later re-request gives `req`=8'h44 again → the grant goes to 6 only after 2 releases.
- **Voluntary handoff**: `req`=8'h03, grantee 0 drops `req[0]` at cycle 2 → `gnt`=8'h02 at the next edge with `hold_cnt`=1 and no bubble.
- **Enable gating**: `en` dropped during a grant → `gnt`=0 next edge. While `en`=0 and `req`≠0, no grant is issued. Raising `en` grants pick(`req`, previous grantee+1) one cycle later.
